// File: rtl/axil_master.sv
// AXI4-Lite master bridging a simple command/response handshake to one
// outstanding AXI transaction at a time; every AXI-facing output is a flop.
module axil_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    m0_axi_aclk,
   input  logic                    m0_axi_aresetn,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,

   output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
   output logic                    m0_axi_awvalid,
   input  logic                    m0_axi_awready,

   output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
   output logic                    m0_axi_wvalid,
   input  logic                    m0_axi_wready,

   input  logic [1:0]              m0_axi_bresp,
   input  logic                    m0_axi_bvalid,
   output logic                    m0_axi_bready,

   output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
   output logic                    m0_axi_arvalid,
   input  logic                    m0_axi_arready,

   input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
   input  logic [1:0]              m0_axi_rresp,
   input  logic                    m0_axi_rvalid,
   output logic                    m0_axi_rready
);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

   state_t                  state_q;
   logic                    awValid_q, wValid_q, bReady_q, arValid_q, rReady_q;
   logic [ADDR_WIDTH-1:0]   awAddr_q, arAddr_q;
   logic [DATA_WIDTH-1:0]   wData_q;
   logic [DATA_WIDTH/8-1:0] wStrb_q;
   logic                    rspValid_q, rspWrite_q;
   logic [DATA_WIDTH-1:0]   rspRdata_q;
   logic [1:0]              rspResp_q;

   logic awHs, wHs, arHs;

   assign awHs = awValid_q && m0_axi_awready;
   assign wHs  = wValid_q && m0_axi_wready;
   assign arHs = arValid_q && m0_axi_arready;

   // Gated by reset so it reads 0 while held in reset and 1 the moment reset lifts.
   assign cmd_ready = (state_q == IDLE) && m0_axi_aresetn;

   assign m0_axi_awaddr  = awAddr_q;
   assign m0_axi_awvalid = awValid_q;
   assign m0_axi_wdata   = wData_q;
   assign m0_axi_wstrb   = wStrb_q;
   assign m0_axi_wvalid  = wValid_q;
   assign m0_axi_bready  = bReady_q;
   assign m0_axi_araddr  = arAddr_q;
   assign m0_axi_arvalid = arValid_q;
   assign m0_axi_rready  = rReady_q;
   assign rsp_valid      = rspValid_q;
   assign rsp_write      = rspWrite_q;
   assign rsp_rdata      = rspRdata_q;
   assign rsp_resp       = rspResp_q;

   always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
      if (!m0_axi_aresetn) begin
         state_q    <= IDLE;
         awValid_q  <= 1'b0;
         wValid_q   <= 1'b0;
         bReady_q   <= 1'b0;
         arValid_q  <= 1'b0;
         rReady_q   <= 1'b0;
         awAddr_q   <= '0;
         arAddr_q   <= '0;
         wData_q    <= '0;
         wStrb_q    <= '0;
         rspValid_q <= 1'b0;
         rspWrite_q <= 1'b0;
         rspRdata_q <= '0;
         rspResp_q  <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  wData_q <= cmd_wdata;
                  wStrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     awAddr_q  <= cmd_addr;
                     awValid_q <= 1'b1;
                     wValid_q  <= 1'b1;
                     state_q   <= WRITE;
                  end else begin
                     arAddr_q  <= cmd_addr;
                     arValid_q <= 1'b1;
                     state_q   <= READ;
                  end
               end
            end
            // AW and W retire independently; a dropped VALID marks its channel done.
            WRITE: begin
               if (awHs) awValid_q <= 1'b0;
               if (wHs)  wValid_q  <= 1'b0;
               if ((!awValid_q || awHs) && (!wValid_q || wHs)) begin
                  bReady_q <= 1'b1;
                  state_q  <= WRESP;
               end
            end
            WRESP: begin
               if (m0_axi_bvalid) begin
                  bReady_q   <= 1'b0;
                  rspResp_q  <= m0_axi_bresp;
                  rspWrite_q <= 1'b1;
                  rspRdata_q <= '0;
                  rspValid_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            READ: begin
               if (arHs) begin
                  arValid_q <= 1'b0;
                  rReady_q  <= 1'b1;
                  state_q   <= RDATA;
               end
            end
            RDATA: begin
               if (m0_axi_rvalid) begin
                  rReady_q   <= 1'b0;
                  rspRdata_q <= m0_axi_rdata;
                  rspResp_q  <= m0_axi_rresp;
                  rspWrite_q <= 1'b0;
                  rspValid_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master.sv
// Randomized bench for axil_master: a memory-backed AXI-Lite slave with tunable
// stalls, a byte-level reference memory, and a scoreboard of expected responses.
module tb_axil_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   axil_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .m0_axi_aclk(clk), .m0_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
      .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
      .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
      .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
      .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        write;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] refMem   [256] = '{default: 32'h0};
   logic [31:0] slaveMem [256] = '{default: 32'h0};

   int passCount = 0;
   int checkCount = 0;
   int timeoutEvents = 0;
   int awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0, rspDelay = 0;
   logic endCheck = 1'b0;

   // The slave answers error for the top quarter of the address map.
   function automatic logic [1:0] respFor(input logic [7:0] a);
      return (a[7:6] == 2'b11) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
   endtask

   // Slave model: samples handshakes on the falling edge, updates its drives just after the rising edge.
   initial begin
      logic sAw, sW, sB, sAr, sR, sRsp, gotAw, gotW, gotAr;
      logic [7:0]  capAddr, capRaddr;
      logic [31:0] capData;
      logic [3:0]  capStrb;
      int awWait, wWait, bWait, arWait, rWait, rspWait;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rsp_ready = 0;
      gotAw = 0; gotW = 0; gotAr = 0;
      capAddr = 0; capRaddr = 0; capData = 0; capStrb = 0;
      awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0; rspWait = 0;
      forever begin
         @(negedge clk);
         sAw  = awvalid && awready;
         sW   = wvalid && wready;
         sB   = bvalid && bready;
         sAr  = arvalid && arready;
         sR   = rvalid && rready;
         sRsp = rsp_valid && rsp_ready;
         if (sAw) capAddr = awaddr;
         if (sW) begin capData = wdata; capStrb = wstrb; end
         if (sAr) capRaddr = araddr;
         @(posedge clk); #1;
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rsp_ready = 0;
            gotAw = 0; gotW = 0; gotAr = 0;
            awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0; rspWait = 0;
            continue;
         end
         if (sAw) begin awready = 0; awWait = 0; gotAw = 1; end
         else if (awvalid && !awready) begin
            if (awWait >= awDelay) awready = 1; else awWait++;
         end
         if (sW) begin wready = 0; wWait = 0; gotW = 1; end
         else if (wvalid && !wready) begin
            if (wWait >= wDelay) wready = 1; else wWait++;
         end
         if (sB) bvalid = 0;
         else if (gotAw && gotW && !bvalid) begin
            if (bWait >= bDelay) begin
               slaveMem[capAddr] = mergeBytes(slaveMem[capAddr], capData, capStrb);
               bresp = respFor(capAddr);
               bvalid = 1; bWait = 0; gotAw = 0; gotW = 0;
            end else bWait++;
         end
         if (sAr) begin arready = 0; arWait = 0; gotAr = 1; end
         else if (arvalid && !arready) begin
            if (arWait >= arDelay) arready = 1; else arWait++;
         end
         if (sR) rvalid = 0;
         else if (gotAr && !rvalid) begin
            if (rWait >= rDelay) begin
               rdata = slaveMem[capRaddr];
               rresp = respFor(capRaddr);
               rvalid = 1; rWait = 0; gotAr = 0;
            end else rWait++;
         end
         if (sRsp) begin rsp_ready = 0; rspWait = 0; end
         else if (rsp_valid && !rsp_ready) begin
            if (rspWait >= rspDelay) rsp_ready = 1; else rspWait++;
         end
      end
   end

   // Monitor/scoreboard: all comparisons happen here on the falling edge.
   initial begin
      logic        prevAw, prevW, prevAr, prevRsp, prevReset, endDone;
      logic [7:0]  prevAwaddr, prevAraddr;
      logic [31:0] prevWdata;
      logic [3:0]  prevWstrb;
      logic [35:0] prevRspBus;
      logic [3:0]  awSeen, wSeen, bSeen, arSeen, rSeen;
      int          seenTimeouts;
      exp_t        e;
      prevAw = 0; prevW = 0; prevAr = 0; prevRsp = 0; prevReset = 0; endDone = 0;
      prevAwaddr = 0; prevAraddr = 0; prevWdata = 0; prevWstrb = 0; prevRspBus = 0;
      awSeen = 0; wSeen = 0; bSeen = 0; arSeen = 0; rSeen = 0; seenTimeouts = 0;
      forever begin
         @(negedge clk);
         if (timeoutEvents != seenTimeouts) begin
            checkOutput("waitTimeout", 64'(timeoutEvents), 64'(seenTimeouts));
            seenTimeouts = timeoutEvents;
         end
         if (endCheck && !endDone) begin
            checkOutput("pendingAtEnd", 64'(expQ.size()), 64'd0);
            endDone = 1;
         end
         if (!rst_n) begin
            checkOutput("resetCtrl", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                        rsp_write, rsp_resp, cmd_ready, awaddr, araddr, wstrb}), 64'd0);
            checkOutput("resetData", {rsp_rdata, wdata}, 64'd0);
            expQ.delete();
            prevAw = 0; prevW = 0; prevAr = 0; prevRsp = 0; prevReset = 1;
            continue;
         end
         if (prevReset) checkOutput("cmdReadyAfterReset", 64'(cmd_ready), 64'd1);
         prevReset = 0;
         if (prevAw) checkOutput("awHeldStable", 64'({awvalid, awaddr}), 64'({1'b1, prevAwaddr}));
         if (prevW)  checkOutput("wHeldStable", 64'({wvalid, wstrb, wdata}),
                                 64'({1'b1, prevWstrb, prevWdata}));
         if (prevAr) checkOutput("arHeldStable", 64'({arvalid, araddr}), 64'({1'b1, prevAraddr}));
         if (prevRsp) checkOutput("rspHeldStable", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp}),
                                  64'(prevRspBus));
         if (expQ.size() > 0) checkOutput("cmdReadyWhileBusy", 64'(cmd_ready), 64'd0);
         if (bready) checkOutput("breadyAfterAwW", 64'({awSeen != 0, wSeen != 0}), 64'd3);

         if (cmd_valid && cmd_ready) begin
            e.write = cmd_write;
            e.addr  = cmd_addr;
            e.wdata = cmd_wdata;
            e.wstrb = cmd_wstrb;
            e.resp  = respFor(cmd_addr);
            e.rdata = cmd_write ? 32'h0 : refMem[cmd_addr];
            expQ.push_back(e);
            awSeen = 0; wSeen = 0; bSeen = 0; arSeen = 0; rSeen = 0;
         end
         if (awvalid && awready) begin
            awSeen++;
            if (expQ.size() > 0) checkOutput("awaddr", 64'(awaddr), 64'(expQ[0].addr));
         end
         if (wvalid && wready) begin
            wSeen++;
            if (expQ.size() > 0) checkOutput("wdataStrb", 64'({wstrb, wdata}),
                                             64'({expQ[0].wstrb, expQ[0].wdata}));
         end
         if (arvalid && arready) begin
            arSeen++;
            if (expQ.size() > 0) checkOutput("araddr", 64'(araddr), 64'(expQ[0].addr));
         end
         if (bvalid && bready) bSeen++;
         if (rvalid && rready) rSeen++;
         if (rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) checkOutput("unexpectedRsp", 64'(rsp_valid), 64'd0);
            else begin
               e = expQ.pop_front();
               checkOutput("rspWrite", 64'(rsp_write), 64'(e.write));
               checkOutput("rspRdata", 64'(rsp_rdata), 64'(e.rdata));
               checkOutput("rspResp", 64'(rsp_resp), 64'(e.resp));
               checkOutput("hsCounts", 64'({awSeen, wSeen, bSeen, arSeen, rSeen}),
                           e.write ? 64'h11100 : 64'h00011);
               if (e.write) refMem[e.addr] = mergeBytes(refMem[e.addr], e.wdata, e.wstrb);
            end
         end

         prevAw     = awvalid && !awready;
         prevAwaddr = awaddr;
         prevW      = wvalid && !wready;
         prevWdata  = wdata;
         prevWstrb  = wstrb;
         prevAr     = arvalid && !arready;
         prevAraddr = araddr;
         prevRsp    = rsp_valid && !rsp_ready;
         prevRspBus = {rsp_valid, rsp_write, rsp_rdata, rsp_resp};
      end
   end

   // Present one command, starting just after a rising edge; keep cmd_valid up unless last.
   task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic last);
      logic accepted;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 300 && !accepted; i++) begin
         @(negedge clk);
         accepted = cmd_ready;
         @(posedge clk); #1;
      end
      if (!accepted) begin
         $display("[TB] FAIL cmdAccept: command at addr 0x%0h not accepted", a);
         timeoutEvents++;
      end
      if (last || !accepted) cmd_valid = 1'b0;
   endtask

   task automatic waitIdle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(posedge clk); #1;
         done = (expQ.size() == 0);
      end
      if (!done) begin
         $display("[TB] FAIL waitIdle: response still outstanding");
         timeoutEvents++;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic sawBready;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] write with immediate slave readies");
      applyStimulus(1'b1, 8'h00, 32'h00056780, 4'hF, 1'b1);
      waitIdle();

      $display("[TB] write with W accepted three cycles before AW");
      awDelay = 3; wDelay = 0;
      applyStimulus(1'b1, 8'h08, 32'h12345678, 4'hF, 1'b1);
      waitIdle();
      awDelay = 0;

      $display("[TB] read after two-cycle AR stall");
      applyStimulus(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b1);
      waitIdle();
      arDelay = 2;
      applyStimulus(1'b0, 8'h04, 32'h0, 4'h0, 1'b1);
      waitIdle();
      arDelay = 0;

      $display("[TB] error response under response backpressure");
      rspDelay = 4;
      applyStimulus(1'b1, 8'hC0, 32'hA5A5A5A5, 4'h3, 1'b1);
      waitIdle();
      rspDelay = 0;

      $display("[TB] reset while waiting for write response");
      bDelay = 20;
      applyStimulus(1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 1'b1);
      sawBready = 1'b0;
      for (int i = 0; i < 50 && !sawBready; i++) begin
         @(posedge clk); #1;
         sawBready = bready;
      end
      if (!sawBready) begin
         $display("[TB] FAIL reachWresp: bready never rose");
         timeoutEvents++;
      end
      #1 rst_n = 1'b0;
      bDelay = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
      waitIdle();
      applyStimulus(1'b0, 8'h04, 32'h0, 4'h0, 1'b1);
      waitIdle();

      $display("[TB] three commands back-to-back");
      applyStimulus(1'b1, 8'h14, 32'h11223344, 4'hF, 1'b0);
      applyStimulus(1'b0, 8'h14, 32'h0, 4'h0, 1'b0);
      applyStimulus(1'b1, 8'h18, 32'h55667788, 4'h5, 1'b1);
      waitIdle();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         awDelay  = $urandom_range(0, 3);
         wDelay   = $urandom_range(0, 3);
         bDelay   = $urandom_range(0, 3);
         arDelay  = $urandom_range(0, 3);
         rDelay   = $urandom_range(0, 3);
         rspDelay = $urandom_range(0, 2);
         applyStimulus(1'($urandom_range(0, 1)),
                       8'(($urandom_range(0, 3) == 0 ? 8'hC0 : 8'h00) + 8'(4 * $urandom_range(0, 5))),
                       32'($urandom), 4'($urandom_range(0, 15)), 1'b1);
         if ($urandom_range(0, 1) == 1) waitIdle();
      end
      waitIdle();

      endCheck = 1'b1;
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
